mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-port synchronous main memory between the instruction-fetch requester and the data-access (memory-stage) requester of the 16-bit core. It grants at most one access per cycle and routes the one-cycle-latency read data back to the requester that issued it. It holds each requester's last read word and provides starvation-bounded priority. It sits between the fetch/mem-stage address and data outputs and the main memory macro.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- STARVE_MAX, 3, consecutive contended cycles the fetch port may lose before it is forced to win (legal range 1..15)

Clock and reset:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset

Fetch port:
- if_req  input  1  fetch read request
- if_adr  input  ADDR_W  fetch address
- if_gnt  output  1  fetch granted this cycle (combinational)
- if_rvalid  output  1  fetch read data valid this cycle
- if_rdat  output  DATA_W  fetch read data / held last word

Data port:
- d_req  input  1  data request
- d_we  input  1  1 = write, 0 = read
- d_adr  input  ADDR_W  data address
- d_wdat  input  DATA_W  write data
- d_gnt  output  1  data granted this cycle (combinational)
- d_rvalid  output  1  data read data valid this cycle
- d_rdat  output  DATA_W  data read data / held last word

Memory side:
- mem_adr  output  ADDR_W  address to RAM
- mem_we  output  1  write enable
- mem_wdat  output  DATA_W  write data
- mem_rdat  input  DATA_W  RAM read data, valid the cycle after the address

Status:
- if_stall  output  1  if_req & ~if_gnt
- d_stall  output  1  d_req & ~d_gnt

## Operation
- Arbitration is combinational per cycle. With only one request, that request wins. With both requests, the data port wins unless starve_cnt == STARVE_MAX, in which case the fetch port wins.
- starve_cnt is 4 bits, reset 0.
  - Increments when if_req & d_req & d_gnt.
  - Clears when if_gnt or when ~if_req.
  - Saturates at STARVE_MAX.
- Memory drive:
  - Fetch winner: mem_adr = if_adr, mem_we = 0, mem_wdat = 0.
  - Data winner: mem_adr = d_adr, mem_we = d_we, mem_wdat = d_wdat.
  - No grant: mem_adr = 0, mem_we = 0, mem_wdat = 0.
- Pending-read tracking uses registered flags pend_if and pend_d (reset 0).
  - pend_if is set for the next cycle iff if_gnt.
  - pend_d is set for the next cycle iff d_gnt & ~d_we.
  - At most one flag is set at a time.
- Read return:
  - if_rvalid = pend_if and d_rvalid = pend_d.
  - When valid, x_rdat = mem_rdat combinationally and hold_x captures mem_rdat at the clock edge.
  - Otherwise x_rdat = hold_x (reset 0).
- Writes produce no rvalid, and the data hold register is unchanged.
- Reset assertion at any time clears the pending flags, hold registers and counter immediately. A read granted in the cycle before reset never returns rvalid.

## Timing
- Grant latency 0: a request that is granted in cycle N has memory signals driven in cycle N.
- Read latency 1: rvalid is high and data is on x_rdat in cycle N+1.
- Writes commit at the rising edge ending cycle N.
- One access per cycle, with full back-to-back throughput. A read return in cycle N+1 and a new grant in cycle N+1 coexist.
- A requester holds req, adr, we and wdat stable while stalled. The arbiter does not latch requests: dropping req while stalled cancels the request.
- Reset values of all outputs: if_gnt = d_gnt = 0 when req = 0; if_rvalid = d_rvalid = 0; if_rdat = d_rdat = 0; mem_adr = mem_we = mem_wdat = 0 when idle; stalls follow req.
- Worst-case fetch wait under continuous contention is STARVE_MAX cycles. The fetch grant comes on contended cycle STARVE_MAX+1.

## Test plan
- Fetch-only read:
  - Stimulus: if_req = 1 with if_adr = 0x0010 for one cycle; RAM[0x0010] = 0xBEEF.
  - Required response: cycle 0 has if_gnt = 1 and mem_adr = 0x0010; cycle 1 has if_rvalid = 1 and if_rdat = 0xBEEF; if_rdat stays 0xBEEF afterwards.
- Data write then read:
  - Stimulus: d_we = 1, d_adr = 0x0200, d_wdat = 0x1234, followed by a read of 0x0200.
  - Required response: mem_we is pulsed once; the write gives no d_rvalid; the read's d_rvalid cycle shows d_rdat = 0x1234.
- Contention:
  - Stimulus: if_req and d_req both held high for 8 cycles with STARVE_MAX = 3.
  - Required response: grant pattern D,D,D,F,D,D,D,F; if_stall is high on all D cycles; fetch rdat returns only after each F cycle.
- Alternating returns:
  - Stimulus: fetch read 0x0001 in cycle 0, data read 0x0002 in cycle 1.
  - Required response: if_rvalid in cycle 1 and d_rvalid in cycle 2 each carry the correct word; no cross-routing occurs and d_rdat is unchanged in cycle 1.
- Reset mid-read:
  - Stimulus: d read granted in cycle 0, rst_n low in cycle 1.
  - Required response: d_rvalid = 0, d_rdat = 0 and starve_cnt = 0 immediately.
- Cancel while stalled:
  - Stimulus: if_req drops while stalled.
  - Required response: no fetch grant, no if_rvalid, and starve_cnt clears.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Fetch/data requester ports and memory-macro side of the memory port arbiter.
// Grant and stall are same-cycle; read data returns one cycle after grant.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              if_req;
   logic [ADDR_W-1:0] if_adr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdat;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_adr;
   logic [DATA_W-1:0] d_wdat;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdat;

   logic [ADDR_W-1:0] mem_adr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdat;
   logic [DATA_W-1:0] mem_rdat;

   logic              if_stall;
   logic              d_stall;

   modport slave (
      input  if_req, if_adr, d_req, d_we, d_adr, d_wdat, mem_rdat,
      output if_gnt, if_rvalid, if_rdat, d_gnt, d_rvalid, d_rdat,
             mem_adr, mem_we, mem_wdat, if_stall, d_stall
   );

   modport master (
      output if_req, if_adr, d_req, d_we, d_adr, d_wdat, mem_rdat,
      input  if_gnt, if_rvalid, if_rdat, d_gnt, d_rvalid, d_rdat,
             mem_adr, mem_we, mem_wdat, if_stall, d_stall
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch vs data access to a single-port RAM; grant latency 0, read data +1 cycle.
// Losing requester sees gnt=0/stall=1 and must hold its request; fetch loss is bounded by STARVE_MAX.
module mem_port_arbiter #(
   parameter int DATA_W     = 16,
   parameter int STARVE_MAX = 3
) (
   input logic              clk,
   input logic              rst_n,
   mem_port_arbiter_if.slave bus
);
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [3:0]        starve_cnt_q, starve_cnt_d;
   logic              pend_if_q, pend_if_d;
   logic              pend_d_q, pend_d_d;
   logic [DATA_W-1:0] hold_if_q, hold_if_d;
   logic [DATA_W-1:0] hold_d_q, hold_d_d;
   logic              if_gnt_c, d_gnt_c;

   always_comb begin
      if_gnt_c = bus.if_req & (~bus.d_req | (starve_cnt_q == STARVE_LIM));
      d_gnt_c  = bus.d_req & ~if_gnt_c;

      bus.if_gnt   = if_gnt_c;
      bus.d_gnt    = d_gnt_c;
      bus.if_stall = bus.if_req & ~if_gnt_c;
      bus.d_stall  = bus.d_req & ~d_gnt_c;

      bus.mem_adr  = '0;
      bus.mem_we   = 1'b0;
      bus.mem_wdat = '0;
      if (if_gnt_c) begin
         bus.mem_adr = bus.if_adr;
      end else if (d_gnt_c) begin
         bus.mem_adr  = bus.d_adr;
         bus.mem_we   = bus.d_we;
         bus.mem_wdat = bus.d_wdat;
      end

      // Counter only climbs while fetch is actively losing to data; saturates at the limit.
      starve_cnt_d = starve_cnt_q;
      if (if_gnt_c || !bus.if_req) begin
         starve_cnt_d = '0;
      end else if (bus.d_req && d_gnt_c && (starve_cnt_q != STARVE_LIM)) begin
         starve_cnt_d = starve_cnt_q + 4'd1;
      end

      pend_if_d = if_gnt_c;
      pend_d_d  = d_gnt_c & ~bus.d_we;

      hold_if_d = pend_if_q ? bus.mem_rdat : hold_if_q;
      hold_d_d  = pend_d_q  ? bus.mem_rdat : hold_d_q;

      bus.if_rvalid = pend_if_q;
      bus.d_rvalid  = pend_d_q;
      bus.if_rdat   = pend_if_q ? bus.mem_rdat : hold_if_q;
      bus.d_rdat    = pend_d_q  ? bus.mem_rdat : hold_d_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt_q <= '0;
         pend_if_q    <= 1'b0;
         pend_d_q     <= 1'b0;
         hold_if_q    <= '0;
         hold_d_q     <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         pend_if_q    <= pend_if_d;
         pend_d_q     <= pend_d_d;
         hold_if_q    <= hold_if_d;
         hold_d_q     <= hold_d_d;
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed + random checks of mem_port_arbiter against a cycle-level reference model and RAM model.
module tb_mem_port_arbiter;
   localparam int STARVE_MAX = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   mem_port_arbiter #(.DATA_W(16), .STARVE_MAX(STARVE_MAX)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   function automatic logic [15:0] init_val(input logic [15:0] a);
      case (a)
         16'h0010: init_val = 16'hBEEF;
         16'h0001: init_val = 16'h1111;
         16'h0002: init_val = 16'h2222;
         default:  init_val = a ^ 16'hC3A5;
      endcase
   endfunction

   // Environment RAM: synchronous single port, one-cycle read latency.
   logic [15:0] ram    [0:65535];
   bit          ram_wr [0:65535];
   always @(posedge clk) begin
      if (bus.mem_we) begin
         ram[bus.mem_adr]    <= bus.mem_wdat;
         ram_wr[bus.mem_adr] <= 1'b1;
      end
      bus.mem_rdat <= ram_wr[bus.mem_adr] ? ram[bus.mem_adr] : init_val(bus.mem_adr);
   end

   // Reference model state
   logic [15:0] m_mem [0:65535];
   bit          m_wr  [0:65535];
   int          lost;
   bit          m_pend_if, m_pend_d;
   logic [15:0] m_pval, m_hold_if, m_hold_d;

   int total = 0;
   int bad   = 0;

   logic        o_if_gnt, o_d_gnt, o_mem_we, o_if_rv, o_d_rv, o_if_stall;
   logic [15:0] o_mem_adr, o_if_rdat, o_d_rdat;

   function automatic logic [15:0] mread(input logic [15:0] a);
      mread = m_wr[a] ? m_mem[a] : init_val(a);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      lost      = 0;
      m_pend_if = 1'b0;
      m_pend_d  = 1'b0;
      m_pval    = '0;
      m_hold_if = '0;
      m_hold_d  = '0;
   endtask

   // Entered just after a rising edge; drives one cycle, checks at the falling edge.
   task automatic cycle(input bit ir, input logic [15:0] ia, input bit dr, input bit dwe,
                        input logic [15:0] da, input logic [15:0] dwd);
      bit          e_fg, e_dg;
      logic [15:0] e_adr, e_wdat, e_if_rdat, e_d_rdat;
      bit          e_we;
      bus.if_req = ir;  bus.if_adr = ia;
      bus.d_req  = dr;  bus.d_we   = dwe; bus.d_adr = da; bus.d_wdat = dwd;

      e_fg = ir && (!dr || lost == STARVE_MAX);
      e_dg = dr && !e_fg;
      e_adr  = e_fg ? ia : (e_dg ? da : 16'h0);
      e_we   = e_dg && dwe;
      e_wdat = (e_dg && dwe) ? dwd : (e_dg ? dwd : 16'h0);
      if (e_fg) e_wdat = 16'h0;
      e_if_rdat = m_pend_if ? m_pval : m_hold_if;
      e_d_rdat  = m_pend_d  ? m_pval : m_hold_d;

      @(negedge clk);
      o_if_gnt = bus.if_gnt;  o_d_gnt = bus.d_gnt;  o_mem_we = bus.mem_we;
      o_mem_adr = bus.mem_adr; o_if_rv = bus.if_rvalid; o_d_rv = bus.d_rvalid;
      o_if_rdat = bus.if_rdat; o_d_rdat = bus.d_rdat; o_if_stall = bus.if_stall;
      chk("if_gnt",    bus.if_gnt,    e_fg);
      chk("d_gnt",     bus.d_gnt,     e_dg);
      chk("mem_adr",   bus.mem_adr,   e_adr);
      chk("mem_we",    bus.mem_we,    e_we);
      chk("mem_wdat",  bus.mem_wdat,  e_wdat);
      chk("if_rvalid", bus.if_rvalid, m_pend_if);
      chk("d_rvalid",  bus.d_rvalid,  m_pend_d);
      chk("if_rdat",   bus.if_rdat,   e_if_rdat);
      chk("d_rdat",    bus.d_rdat,    e_d_rdat);
      chk("if_stall",  bus.if_stall,  ir && !e_fg);
      chk("d_stall",   bus.d_stall,   dr && !e_dg);

      if (m_pend_if) m_hold_if = m_pval;
      if (m_pend_d)  m_hold_d  = m_pval;
      m_pend_if = e_fg;
      m_pend_d  = e_dg && !dwe;
      if (e_fg) m_pval = mread(ia);
      else if (e_dg && !dwe) m_pval = mread(da);
      if (e_dg && dwe) begin
         m_mem[da] = dwd;
         m_wr[da]  = 1'b1;
      end
      if (!ir || e_fg) lost = 0;
      else if (dr) lost = lost + 1;

      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
   endtask

   initial begin
      bit pat [0:7];
      pat = '{0, 0, 0, 1, 0, 0, 0, 1};
      model_reset();
      bus.if_req = 1'b0; bus.if_adr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_adr = '0; bus.d_wdat = '0;

      // Reset state
      #3;
      chk("rst_if_gnt",  bus.if_gnt,    1'b0);
      chk("rst_d_rv",    bus.d_rvalid,  1'b0);
      chk("rst_if_rdat", bus.if_rdat,   16'h0);
      chk("rst_d_rdat",  bus.d_rdat,    16'h0);
      chk("rst_mem_adr", bus.mem_adr,   16'h0);
      chk("rst_mem_we",  bus.mem_we,    1'b0);
      #9 rst_n = 1'b1;
      @(posedge clk); #1;

      // Fetch-only read
      cycle(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0);
      chk("fo_gnt", o_if_gnt, 1'b1);
      chk("fo_adr", o_mem_adr, 16'h0010);
      idle();
      chk("fo_rv",   o_if_rv,   1'b1);
      chk("fo_rdat", o_if_rdat, 16'hBEEF);
      idle();
      chk("fo_hold", o_if_rdat, 16'hBEEF);

      // Data write then read
      cycle(1'b0, 16'h0, 1'b1, 1'b1, 16'h0200, 16'h1234);
      chk("wr_we", o_mem_we, 1'b1);
      cycle(1'b0, 16'h0, 1'b1, 1'b0, 16'h0200, 16'h0);
      chk("wr_no_rv", o_d_rv, 1'b0);
      chk("rd_we0",   o_mem_we, 1'b0);
      idle();
      chk("rd_rv",   o_d_rv,   1'b1);
      chk("rd_rdat", o_d_rdat, 16'h1234);

      // Contention: D,D,D,F repeating
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 16'h0003, 1'b1, 1'b0, 16'h0004, 16'h0);
         chk("cont_pat", o_if_gnt, pat[i]);
         chk("cont_stall", o_if_stall, !pat[i]);
      end
      idle();
      chk("cont_last_rv", o_if_rv, 1'b1);

      // Alternating returns
      idle();
      cycle(1'b1, 16'h0001, 1'b0, 1'b0, 16'h0, 16'h0);
      cycle(1'b0, 16'h0, 1'b1, 1'b0, 16'h0002, 16'h0);
      chk("alt_if_rv",   o_if_rv,   1'b1);
      chk("alt_if_rdat", o_if_rdat, 16'h1111);
      chk("alt_d_rv0",   o_d_rv,    1'b0);
      chk("alt_d_keep",  o_d_rdat,  16'h0004 ^ 16'hC3A5);
      idle();
      chk("alt_d_rv",    o_d_rv,    1'b1);
      chk("alt_d_rdat",  o_d_rdat,  16'h2222);
      chk("alt_if_rv0",  o_if_rv,   1'b0);

      // Cancel while stalled
      cycle(1'b1, 16'h0007, 1'b1, 1'b0, 16'h0008, 16'h0);
      chk("cx_stalled", o_if_stall, 1'b1);
      chk("cx_cnt1", dut.starve_cnt_q, 4'd1);
      cycle(1'b0, 16'h0007, 1'b1, 1'b0, 16'h0008, 16'h0);
      chk("cx_no_gnt", o_if_gnt, 1'b0);
      chk("cx_cnt0", dut.starve_cnt_q, 4'd0);
      idle();
      chk("cx_no_rv", o_if_rv, 1'b0);

      // Reset mid-read
      cycle(1'b1, 16'h0005, 1'b1, 1'b0, 16'h0006, 16'h0);
      bus.if_req = 1'b0; bus.d_req = 1'b0;
      chk("mr_pre_rv",  bus.d_rvalid, 1'b1);
      chk("mr_pre_cnt", dut.starve_cnt_q, 4'd1);
      rst_n = 1'b0;
      #1;
      chk("mr_d_rv",   bus.d_rvalid, 1'b0);
      chk("mr_d_rdat", bus.d_rdat,   16'h0);
      chk("mr_if_rdat", bus.if_rdat, 16'h0);
      chk("mr_cnt",    dut.starve_cnt_q, 4'd0);
      model_reset();
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      idle();

      // Random traffic over a small address window
      for (int n = 0; n < 400; n++) begin
         cycle(1'($urandom_range(0, 1)), 16'h0100 + 16'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               16'h0100 + 16'($urandom_range(0, 15)), 16'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
